// File: rtl/free_list_ctrl_pkg.sv
// Shared CPU sizing constants for rename, ROB and the physical-register free list.
package free_list_ctrl_pkg;

   localparam int CPU_PREG_WIDTH = 6;
   localparam int CPU_NUM_AREGS  = 32;
   localparam int CPU_NUM_PREGS  = 2 * CPU_NUM_AREGS;

   typedef logic [CPU_PREG_WIDTH-1:0] preg_t;

endpackage

// File: rtl/free_list_ctrl_fl_ptr.sv
// Circular-buffer pointer: index plus wrap bit, advanced by one on inc.
module fl_ptr #(
   parameter int   DEPTH    = 32,
   parameter logic RST_WRAP = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   output logic [$clog2(DEPTH):0]   ptr
);

   localparam int IDX_W = $clog2(DEPTH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= {RST_WRAP, IDX_W'(0)};
      end else if (inc) begin
         if (ptr[IDX_W-1:0] == IDX_W'(DEPTH - 1))
            ptr <= {~ptr[IDX_W], IDX_W'(0)};
         else
            ptr <= ptr + (IDX_W + 1)'(1);
      end
   end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: FIFO of free tags, zero-latency grant at the head,
// retired tags appended at the tail. Reset fills it with p(NUM_AREGS)..p(2*NUM_AREGS-1).
module free_list_ctrl
   import free_list_ctrl_pkg::*;
#(
   parameter int PREG_WIDTH = CPU_PREG_WIDTH,
   parameter int NUM_AREGS  = CPU_NUM_AREGS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_req,
   output logic                  alloc_valid,
   output logic [PREG_WIDTH-1:0] alloc_preg,
   input  logic                  free_valid,
   input  logic [PREG_WIDTH-1:0] free_preg,
   output logic                  empty,
   output logic                  stall_out,
   output logic [PREG_WIDTH-1:0] free_count,
   output logic                  overflow_err
);

   localparam int IDX_W = $clog2(NUM_AREGS);

   logic [PREG_WIDTH-1:0] fifo [NUM_AREGS];
   logic [IDX_W:0]        head;
   logic [IDX_W:0]        tail;
   logic                  full;
   logic                  grant;
   logic                  free_nz;
   logic                  free_acc;

   assign empty = (head == tail);
   assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);

   assign grant       = alloc_req & ~empty;
   assign alloc_valid = grant;
   assign alloc_preg  = fifo[head[IDX_W-1:0]];
   assign stall_out   = alloc_req & empty;

   // p0 is the hardwired x0 mapping and never circulates.
   assign free_nz  = free_valid && (free_preg != '0);
   // A free into a full list only fits if the head slot is vacated in the same cycle.
   assign free_acc = free_nz && (!full || grant);

   fl_ptr #(
      .DEPTH    (NUM_AREGS),
      .RST_WRAP (1'b0)
   ) u_head (
      .clk (clk),
      .rst (rst),
      .inc (grant),
      .ptr (head)
   );

   fl_ptr #(
      .DEPTH    (NUM_AREGS),
      .RST_WRAP (1'b1)
   ) u_tail (
      .clk (clk),
      .rst (rst),
      .inc (free_acc),
      .ptr (tail)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_AREGS; i++)
            fifo[i] <= PREG_WIDTH'(NUM_AREGS + i);
      end else if (free_acc) begin
         fifo[tail[IDX_W-1:0]] <= free_preg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         free_count   <= PREG_WIDTH'(NUM_AREGS);
         overflow_err <= 1'b0;
      end else begin
         if (free_nz && full && !grant)
            overflow_err <= 1'b1;
         case ({free_acc, grant})
            2'b10:   free_count <= free_count + PREG_WIDTH'(1);
            2'b01:   free_count <= free_count - PREG_WIDTH'(1);
            default: free_count <= free_count;
         endcase
      end
   end

endmodule
